// File: rtl/uart2pwm_pkg.sv
// uart2pwm shared definitions: FSM state encodings,
// default bit timing, frame constants and a 2-of-3 vote helper.
package uart2pwm_pkg;

    // 50 MHz clock / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DATA_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart2pwm_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module uart2pwm_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart2pwm_rx.sv
// UART 8N1 receiver with mid-bit 3-sample majority vote.
// Ports: clk, rst (sync, active-high), rx (async serial in),
//        data (last good byte), valid / frame_err (1-cycle strobes), busy.
module uart2pwm_rx
    import uart2pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int MID = CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1   = CW'(MID);
    localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
    localparam logic [2:0]    I_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    uart2pwm_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;
    logic          v0, v0_n;
    logic          v1, v1_n;

    logic wrap, dec, bitv;

    assign wrap = (cnt == C_LAST);
    assign dec  = (cnt == C_DEC);
    // Third sample is the live rx_s at the decision cycle
    assign bitv = maj3(v0, v1, rx_s);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            v0        <= 1'b0;
            v1        <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            v0        <= v0_n;
            v1        <= v1_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = wrap ? '0 : cnt + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        v0_n    = (cnt == C_S0) ? rx_s : v0;
        v1_n    = (cnt == C_S1) ? rx_s : v1;

        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (dec && bitv) begin
                    // Start bit did not hold: treat as a glitch
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (dec) begin
                    shift_n = {bitv, shift[7:1]};
                end
                if (wrap) begin
                    if (idx == I_LAST) begin
                        state_n = ST_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Decide at mid stop bit so the next start edge
                // can be caught with no inter-frame gap
                if (dec) begin
                    cnt_n = '0;
                    if (bitv) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart2pwm_rx.sv
// Testbench for uart2pwm_rx: directed and random frames
// against a schedule-based model of strobe timing and data.
module tb_uart2pwm_rx;

    localparam int CPB  = 10;
    localparam int MID  = CPB / 2;
    localparam int SYNC = 2;
    // From rx_s first low (t0) to strobe cycle
    localparam int LAT  = 1 + 9 * CPB + MID + 2;
    localparam int NCYC = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart2pwm_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         ev  [NCYC];
    bit         ef  [NCYC];
    bit         clr [NCYC];
    logic [7:0] ed  [NCYC];

    int total = 0;
    int bad = 0;
    int nv_obs = 0;
    int nf_obs = 0;
    int nv_exp = 0;
    int nf_exp = 0;
    logic [7:0] exp_data = 8'h00;
    bit chk_on = 1'b0;

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit wv;
        bit wf;
        if (chk_on) begin
            wv = 1'b0;
            wf = 1'b0;
            if (cyc < NCYC) begin
                if (clr[cyc]) exp_data = 8'h00;
                if (ev[cyc]) exp_data = ed[cyc];
                wv = ev[cyc];
                wf = ef[cyc];
            end
            chk("valid", {31'd0, valid}, {31'd0, wv});
            chk("frame_err", {31'd0, frame_err}, {31'd0, wf});
            chk("data", {24'd0, data}, {24'd0, exp_data});
            if (valid) nv_obs++;
            if (frame_err) nf_obs++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Start bit first driven on the pin in cycle n
    task automatic sched(
        input int         n,
        input bit         good,
        input logic [7:0] b
    );
        int t;
        t = n + SYNC + LAT;
        if (t < NCYC) begin
            if (good) begin
                ev[t] = 1'b1;
                ed[t] = b;
                nv_exp++;
            end else begin
                ef[t] = 1'b1;
                nf_exp++;
            end
        end
    endtask

    task automatic send_frame(
        input logic [7:0] b,
        input bit         stop,
        input int         spike
    );
        int   k;
        logic v;
        sched(cyc, stop, b);
        for (int c = 0; c < 10 * CPB; c++) begin
            k = c / CPB;
            if (k == 0) v = 1'b0;
            else if (k == 9) v = stop;
            else v = b[k-1];
            if (c == spike) v = ~v;
            rx = v;
            tick();
        end
    endtask

    task automatic glitch(input int len);
        for (int c = 0; c < 20; c++) begin
            rx = (c < len) ? 1'b0 : 1'b1;
            if (c == 3) chk("busy_glitch", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("busy_after_glitch", {31'd0, busy}, 32'd0);
    endtask

    task automatic brk();
        int f0;
        f0 = nf_exp;
        sched(cyc, 1'b0, 8'h00);
        rx = 1'b0;
        repeat (300) tick();
        idle(12);
        chk("break_one_ferr", nf_exp - f0, 32'd1);
        chk("break_obs_ferr", nf_obs, nf_exp);
    endtask

    task automatic abort_frame(input logic [7:0] b);
        for (int c = 0; c < 30; c++) begin
            rx = (c < CPB) ? 1'b0 : b[(c / CPB) - 1];
            tick();
        end
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        rst = 1'b0;
        clr[cyc] = 1'b1;
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_ferr", {31'd0, frame_err}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", {24'd0, data}, 32'd0);
        idle(150);
    endtask

    initial begin
        int kind;
        int sp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) tick();
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;
        idle(5);

        // Single byte, literal latency of 100 cycles at CPB=10
        send_frame(8'hA5, 1'b1, -1);
        chk("a5_valid_at_100", {31'd0, valid}, 32'd1);
        chk("a5_data", {24'd0, data}, 32'h0000_00A5);
        idle(20);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        chk("b2b_last", {24'd0, data}, 32'h0000_003C);
        chk("b2b_valid", {31'd0, valid}, 32'd1);
        idle(20);

        glitch(3);
        send_frame(8'h5A, 1'b1, -1);
        chk("after_glitch", {24'd0, data}, 32'h0000_005A);
        idle(20);

        send_frame(8'h81, 1'b0, -1);
        chk("ferr_pulse", {31'd0, frame_err}, 32'd1);
        chk("ferr_keep", {24'd0, data}, 32'h0000_005A);
        idle(20);

        brk();
        send_frame(8'h42, 1'b1, -1);
        chk("after_break", {24'd0, data}, 32'h0000_0042);
        idle(20);

        // Spike lands on the rx_s sample at cnt=MID of data bit 3
        send_frame(8'h0F, 1'b1, 4 * CPB + MID + 1);
        chk("spike_0f", {24'd0, data}, 32'h0000_000F);
        idle(20);

        abort_frame(8'h96);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                sp = ($urandom_range(0, 1) == 1)
                     ? $urandom_range(CPB, 9 * CPB - 1) : -1;
                send_frame(8'($urandom), 1'b1, sp);
                idle($urandom_range(0, 15));
            end else if (kind < 9) begin
                send_frame(8'($urandom), 1'b0, -1);
                idle($urandom_range(5, 20));
            end else begin
                glitch($urandom_range(1, 4));
            end
        end

        idle(150);
        chk("total_valid", nv_obs, nv_exp);
        chk("total_ferr", nf_obs, nf_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
